// File: rtl/router_pkg.sv
// Shared types and width helpers for the 1xN packet router.
package router_pkg;

    // Router packet FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DROP = 2'd2
    } state_e;

    // Bits needed to index n distinct values (at least 1).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_w(input int max_val);
        return idx_w(max_val + 1);
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Synchronous first-word-fall-through FIFO with flush, one per output port.
// Pointers carry one extra wrap bit to distinguish full from empty.
module router_fifo
    import router_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              we,
    input  logic              re,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int PW = idx_w(FIFO_DEPTH);

    logic [PW:0]       wr_ptr_q, wr_ptr_d;
    logic [PW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              do_wr, do_rd;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_wr = we && !full;
    assign do_rd = re && !empty;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];

    // Pointer next-state; flush wins over any concurrent read or write.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
            if (do_rd) rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    // Pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem_q[wr_ptr_q[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/router_nport.sv
// Parametrised 1xN packet router: steers framed packets (header, payload,
// parity) into per-port FWFT FIFOs, checks parity and drops bad addresses.
// Optional idle-read flush of output FIFOs is enabled by ROUTER_TIMEOUT_EN.
module router_nport
    import router_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        pkt_valid,
    input  logic [DATA_W-1:0]           data_in,
    output logic                        busy,
    output logic                        err,
    input  logic [NUM_PORTS-1:0]        re,
    output logic [NUM_PORTS-1:0]        vld_out,
    output logic [NUM_PORTS*DATA_W-1:0] data_out
);

    localparam int               ADDR_W = idx_w(NUM_PORTS);
    localparam logic [ADDR_W:0]  NP_L   = (ADDR_W+1)'(NUM_PORTS);

    state_e              state_q;
    logic [DATA_W-1:0]   acc_q;
    logic [ADDR_W-1:0]   tgt_q;
    logic                err_q;

    logic [NUM_PORTS-1:0] fifo_we, fifo_full, fifo_empty, flush;
    logic [ADDR_W-1:0]    hdr_addr;
    logic                 hdr_ok, hdr_empty, tgt_full, tgt_flush;

    assign hdr_addr = data_in[ADDR_W-1:0];
    assign hdr_ok   = ({1'b0, hdr_addr} < NP_L);
    assign vld_out  = ~fifo_empty;
    assign err      = err_q;

    // Per-port status lookup for the incoming header and the latched target.
    always_comb begin
        hdr_empty = 1'b0;
        tgt_full  = 1'b0;
        tgt_flush = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (hdr_addr == ADDR_W'(i)) hdr_empty = fifo_empty[i];
            if (tgt_q == ADDR_W'(i)) begin
                tgt_full  = fifo_full[i];
                tgt_flush = flush[i];
            end
        end
    end

    // Source backpressure: held header for a busy port, or full target.
    always_comb begin
        busy = 1'b0;
        if (rstn) begin
            case (state_q)
                IDLE:    busy = pkt_valid && hdr_ok && !hdr_empty;
                LOAD:    busy = tgt_full;
                default: busy = 1'b0;
            endcase
        end
    end

    // FIFO write strobes: header on acceptance in IDLE, every accepted byte in LOAD.
    always_comb begin
        fifo_we = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            fifo_we[i] = (state_q == IDLE && pkt_valid && hdr_ok && hdr_empty &&
                          hdr_addr == ADDR_W'(i)) ||
                         (state_q == LOAD && !tgt_full && tgt_q == ADDR_W'(i));
        end
    end

    // Packet FSM with parity accumulator, target latch and registered err.
    // A flush of the target while loading diverts the rest of the packet to
    // DROP; if the flushed cycle carries the parity byte, err fires directly.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            acc_q   <= '0;
            tgt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pkt_valid) begin
                        if (!hdr_ok) begin
                            state_q <= DROP;
                        end else if (hdr_empty) begin
                            acc_q   <= data_in;
                            tgt_q   <= hdr_addr;
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (!tgt_full) begin
                        if (!pkt_valid) begin
                            err_q   <= tgt_flush || (data_in != acc_q);
                            acc_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            acc_q <= acc_q ^ data_in;
                            if (tgt_flush) state_q <= DROP;
                        end
                    end else if (tgt_flush) begin
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (!pkt_valid) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ROUTER_TIMEOUT_EN
    localparam int TW = cnt_w(TIMEOUT);

    logic [TW-1:0] cnt_q [NUM_PORTS];
    logic [TW-1:0] cnt_d [NUM_PORTS];

    // Idle-read counters; reaching TIMEOUT flushes that FIFO on the next edge.
    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            flush[i] = (cnt_q[i] == TW'(TIMEOUT));
            if (flush[i] || fifo_empty[i] || re[i]) cnt_d[i] = '0;
            else                                    cnt_d[i] = cnt_q[i] + TW'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!rstn) cnt_q[i] <= '0;
            else       cnt_q[i] <= cnt_d[i];
        end
    end
`else
    // No automatic flushing in this build.
    always_comb begin
        flush = '0;
    end
`endif

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        router_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .flush (flush[g]),
            .we    (fifo_we[g]),
            .re    (re[g]),
            .wdata (data_in),
            .rdata (data_out[g*DATA_W +: DATA_W]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g])
        );
    end

endmodule

// File: tb/tb_router_nport.sv
// Directed self-checking bench for router_nport (DATA_W=8, NUM_PORTS=3,
// FIFO_DEPTH=16, TIMEOUT=30). Expectations follow ROUTER_TIMEOUT_EN.
module tb_router_nport;

    localparam int DW = 8;
    localparam int NP = 3;
    localparam int FD = 16;
    localparam int TO = 30;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             pkt_valid = 1'b0;
    logic [DW-1:0]    data_in = '0;
    logic             busy, err;
    logic [NP-1:0]    re = '0;
    logic [NP-1:0]    vld_out;
    logic [NP*DW-1:0] data_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    router_nport #(
        .DATA_W     (DW),
        .NUM_PORTS  (NP),
        .FIFO_DEPTH (FD),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .pkt_valid (pkt_valid),
        .data_in   (data_in),
        .busy      (busy),
        .err       (err),
        .re        (re),
        .vld_out   (vld_out),
        .data_out  (data_out)
    );

    // Present one byte, wait (bounded) for busy low, then let it be consumed.
    task automatic send_byte(input logic v, input logic [7:0] d);
        int unsigned n = 0;
        pkt_valid = v;
        data_in   = d;
        #1;
        while (busy && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        if (busy) begin
            n_cmp++; n_bad++;
            $display("FAIL send_stall busy=%b required 0 after %0d cycles", busy, n);
        end
        @(posedge clk); #1;
    endtask

    // Sample the head of port p, then pop it.
    task automatic pop(input int p, output logic v, output logic [7:0] d);
        v = vld_out[p];
        d = data_out[p*DW +: DW];
        re[p] = 1'b1;
        @(posedge clk); #1;
        re[p] = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        pkt_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b required 0", busy); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b required 0", err); end
        n_cmp++; if (vld_out !== 3'b000) begin n_bad++; $display("FAIL reset_vld got %b required 000", vld_out); end
        n_cmp++; if (data_out !== 24'h0) begin n_bad++; $display("FAIL reset_data got %h required 000000", data_out); end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_good_packet();
        logic [7:0] e [5] = '{8'h0A, 8'h11, 8'h22, 8'h33, 8'h0A};
        logic v; logic [7:0] d;
        send_byte(1'b1, 8'h0A);
        n_cmp++; if (vld_out !== 3'b100) begin n_bad++; $display("FAIL good_vld_after_hdr got %b required 100", vld_out); end
        send_byte(1'b1, 8'h11);
        send_byte(1'b1, 8'h22);
        send_byte(1'b1, 8'h33);
        send_byte(1'b0, 8'h0A);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL good_err got %b required 0", err); end
        for (int k = 0; k < 5; k++) begin
            pop(2, v, d);
            n_cmp++;
            if ({v, d} !== {1'b1, e[k]}) begin
                n_bad++;
                $display("FAIL good_pop%0d got vld=%b data=%h required vld=1 data=%h", k, v, d, e[k]);
            end
        end
        n_cmp++; if (vld_out !== 3'b000) begin n_bad++; $display("FAIL good_drained got %b required 000", vld_out); end
    endtask

    task automatic test_bad_parity();
        logic [7:0] e [5] = '{8'h0A, 8'h11, 8'h22, 8'h33, 8'h0B};
        logic v; logic [7:0] d;
        send_byte(1'b1, 8'h0A);
        send_byte(1'b1, 8'h11);
        send_byte(1'b1, 8'h22);
        send_byte(1'b1, 8'h33);
        send_byte(1'b0, 8'h0B);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL badpar_err got %b required 1", err); end
        @(posedge clk); #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL badpar_err_width got %b required 0", err); end
        for (int k = 0; k < 5; k++) begin
            pop(2, v, d);
            n_cmp++;
            if ({v, d} !== {1'b1, e[k]}) begin
                n_bad++;
                $display("FAIL badpar_pop%0d got vld=%b data=%h required vld=1 data=%h", k, v, d, e[k]);
            end
        end
    endtask

    task automatic test_full_backpressure();
        logic [7:0] pl [20];
        logic [7:0] e [22];
        logic [7:0] par;
        logic v; logic [7:0] d;
        int idx = 0;
        par = 8'h01;
        for (int i = 0; i < 20; i++) begin
            pl[i] = 8'h40 + 8'(i);
            par   = par ^ pl[i];
            e[i+1] = pl[i];
        end
        e[0]  = 8'h01;
        e[21] = par;
        send_byte(1'b1, 8'h01);
        for (int i = 0; i < 15; i++) send_byte(1'b1, pl[i]);
        // 16 bytes stored: the 17th must see busy
        pkt_valid = 1'b1;
        data_in   = pl[15];
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL full_busy got %b required 1", busy); end
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL full_busy_hold got %b required 1", busy); end
        pop(1, v, d);
        n_cmp++; if ({v, d} !== {1'b1, e[idx]}) begin n_bad++; $display("FAIL full_pop%0d got vld=%b data=%h required vld=1 data=%h", idx, v, d, e[idx]); end
        idx++;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_release got %b required 0", busy); end
        send_byte(1'b1, pl[15]);
        for (int i = 16; i < 20; i++) begin
            pop(1, v, d);
            n_cmp++; if ({v, d} !== {1'b1, e[idx]}) begin n_bad++; $display("FAIL full_pop%0d got vld=%b data=%h required vld=1 data=%h", idx, v, d, e[idx]); end
            idx++;
            send_byte(1'b1, pl[i]);
        end
        pop(1, v, d);
        n_cmp++; if ({v, d} !== {1'b1, e[idx]}) begin n_bad++; $display("FAIL full_pop%0d got vld=%b data=%h required vld=1 data=%h", idx, v, d, e[idx]); end
        idx++;
        send_byte(1'b0, par);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL full_err got %b required 0", err); end
        while (idx < 22) begin
            pop(1, v, d);
            n_cmp++; if ({v, d} !== {1'b1, e[idx]}) begin n_bad++; $display("FAIL full_pop%0d got vld=%b data=%h required vld=1 data=%h", idx, v, d, e[idx]); end
            idx++;
        end
        n_cmp++; if (vld_out !== 3'b000) begin n_bad++; $display("FAIL full_drained got %b required 000", vld_out); end
    endtask

    task automatic test_drop();
        logic [7:0] b [4] = '{8'h03, 8'h55, 8'h66, 8'h30};
        logic       bv [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            pkt_valid = bv[k];
            data_in   = b[k];
            #1;
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drop_busy%0d got %b required 0", k, busy); end
            @(posedge clk); #1;
        end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL drop_err got %b required 1", err); end
        n_cmp++; if (vld_out !== 3'b000) begin n_bad++; $display("FAIL drop_vld got %b required 000", vld_out); end
        @(posedge clk); #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL drop_err_width got %b required 0", err); end
    endtask

    task automatic test_timeout();
        logic v; logic [7:0] d;
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h5A);
        send_byte(1'b1, 8'h5B);
        send_byte(1'b0, 8'h01);
        repeat (27) begin @(posedge clk); #1; end
        n_cmp++; if (vld_out[0] !== 1'b1) begin n_bad++; $display("FAIL tmo_before got %b required 1", vld_out[0]); end
        @(posedge clk); #1;
`ifdef ROUTER_TIMEOUT_EN
        n_cmp++; if (vld_out[0] !== 1'b0) begin n_bad++; $display("FAIL tmo_flushed got %b required 0", vld_out[0]); end
        n_cmp++; if (data_out[7:0] !== 8'h00) begin n_bad++; $display("FAIL tmo_data got %h required 00", data_out[7:0]); end
`else
        repeat (100) begin @(posedge clk); #1; end
        n_cmp++; if (vld_out[0] !== 1'b1) begin n_bad++; $display("FAIL notmo_vld got %b required 1", vld_out[0]); end
        pop(0, v, d);
        n_cmp++; if ({v, d} !== 9'h100) begin n_bad++; $display("FAIL notmo_pop0 got vld=%b data=%h required vld=1 data=00", v, d); end
        pop(0, v, d);
        n_cmp++; if ({v, d} !== 9'h15A) begin n_bad++; $display("FAIL notmo_pop1 got vld=%b data=%h required vld=1 data=5a", v, d); end
        pop(0, v, d);
        n_cmp++; if ({v, d} !== 9'h15B) begin n_bad++; $display("FAIL notmo_pop2 got vld=%b data=%h required vld=1 data=5b", v, d); end
        pop(0, v, d);
        n_cmp++; if ({v, d} !== 9'h101) begin n_bad++; $display("FAIL notmo_pop3 got vld=%b data=%h required vld=1 data=01", v, d); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0] e0a [3] = '{8'h00, 8'h12, 8'h12};
        logic [7:0] e2  [3] = '{8'h02, 8'h34, 8'h36};
        logic [7:0] e0b [3] = '{8'h00, 8'h44, 8'h44};
        logic v; logic [7:0] d;
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h12);
        send_byte(1'b0, 8'h12);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL b2b_errA got %b required 0", err); end
        send_byte(1'b1, 8'h02);
        send_byte(1'b1, 8'h34);
        send_byte(1'b0, 8'h36);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL b2b_errB got %b required 0", err); end
        n_cmp++; if (vld_out !== 3'b101) begin n_bad++; $display("FAIL b2b_vld got %b required 101", vld_out); end
        // header for the still-occupied port 0 is held
        pkt_valid = 1'b1;
        data_in   = 8'h00;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hold_busy got %b required 1", busy); end
        for (int k = 0; k < 3; k++) begin
            pop(0, v, d);
            n_cmp++; if ({v, d} !== {1'b1, e0a[k]}) begin n_bad++; $display("FAIL hold_pop%0d got vld=%b data=%h required vld=1 data=%h", k, v, d, e0a[k]); end
        end
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hold_release got %b required 0", busy); end
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h44);
        send_byte(1'b0, 8'h44);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL hold_err got %b required 0", err); end
        for (int k = 0; k < 3; k++) begin
            pop(2, v, d);
            n_cmp++; if ({v, d} !== {1'b1, e2[k]}) begin n_bad++; $display("FAIL b2b_p2pop%0d got vld=%b data=%h required vld=1 data=%h", k, v, d, e2[k]); end
        end
        for (int k = 0; k < 3; k++) begin
            pop(0, v, d);
            n_cmp++; if ({v, d} !== {1'b1, e0b[k]}) begin n_bad++; $display("FAIL b2b_p0pop%0d got vld=%b data=%h required vld=1 data=%h", k, v, d, e0b[k]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e [3] = '{8'h01, 8'h7E, 8'h7F};
        logic v; logic [7:0] d;
        send_byte(1'b1, 8'h02);
        send_byte(1'b1, 8'h10);
        pkt_valid = 1'b1;
        data_in   = 8'h20;
        rstn      = 1'b0;
        @(posedge clk); #1;
        rstn      = 1'b1;
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        #1;
        n_cmp++; if (vld_out !== 3'b000) begin n_bad++; $display("FAIL rstmid_vld got %b required 000", vld_out); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b required 0", busy); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rstmid_err got %b required 0", err); end
        @(posedge clk); #1;
        send_byte(1'b1, 8'h01);
        send_byte(1'b1, 8'h7E);
        send_byte(1'b0, 8'h7F);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rstmid_pkt_err got %b required 0", err); end
        n_cmp++; if (vld_out !== 3'b010) begin n_bad++; $display("FAIL rstmid_pkt_vld got %b required 010", vld_out); end
        for (int k = 0; k < 3; k++) begin
            pop(1, v, d);
            n_cmp++; if ({v, d} !== {1'b1, e[k]}) begin n_bad++; $display("FAIL rstmid_pop%0d got vld=%b data=%h required vld=1 data=%h", k, v, d, e[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_full_backpressure();
        test_drop();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
